// File: rtl/fir_cascade_pkg.sv
// fir_cascade_pkg: shared widths, sample/product types and saturation helper for the FIR cascade
package fir_cascade_pkg;
  localparam int DEF_PROD_W = 24;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_ACC_W = 32;
  typedef logic signed [DEF_PROD_W-1:0] product_t;
  typedef logic signed [DEF_OUT_W-1:0] sample_t;
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
endpackage

// File: rtl/fir_requant.sv
// fir_requant: round (FIR_TAP_ACC_ROUND_EN) or truncate, arithmetic shift and saturate a sum to OUT_W
module fir_requant
  import fir_cascade_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = 7,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] i_sum,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_sat
);
  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_sh;
  logic signed [63:0]    w_wide;
  logic signed [63:0]    w_cl;
  assign w_ext = {i_sum[ACC_W-1], i_sum};
`ifdef FIR_TAP_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} <<< (SHIFT - 1);
  assign w_sh = (w_ext + RND) >>> SHIFT;
`else
  assign w_sh = w_ext >>> SHIFT;
`endif
  assign w_wide   = {{(63 - ACC_W){w_sh[ACC_W]}}, w_sh};
  assign w_cl     = sat_clamp(w_wide, OUT_W);
  assign o_sample = w_cl[OUT_W-1:0];
  assign o_sat    = w_cl != w_wide;
endmodule

// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator: sums NTAPS signed products per sample, requantises and hands it downstream.
// Rounding before the shift is enabled by defining FIR_TAP_ACC_ROUND_EN.
module fir_tap_accumulator
  import fir_cascade_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int NTAPS  = 8,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SHIFT  = 7,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    prod_tvalid,
  output logic                    prod_tready,
  input  logic signed [PROD_W-1:0] prod_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic signed [OUT_W-1:0] out_tdata,
  output logic                    sat_flag
);
  localparam int CW = $clog2(NTAPS);
  if (ACC_W < PROD_W + $clog2(NTAPS) || ACC_W > 62 || NTAPS < 2 || SHIFT < 1) begin : g_bad_cfg
    $error("fir_tap_accumulator: invalid ACC_W/NTAPS/SHIFT");
  end
  logic [CW-1:0]            r_tap_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [OUT_W-1:0]  w_q;
  logic                     w_sat;
  logic                     w_last;
  logic                     w_fire;
  assign w_last      = r_tap_cnt == CW'(NTAPS - 1);
  assign prod_tready = !w_last || !out_tvalid || out_tready;
  assign w_fire      = prod_tvalid && prod_tready;
  assign w_ext       = {{(ACC_W - PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};
  assign w_sum       = r_acc + w_ext;
  fir_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_requant (
    .i_sum(w_sum),
    .o_sample(w_q),
    .o_sat(w_sat)
  );
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tap_cnt  <= '0;
      r_acc      <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      sat_flag   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_tap_cnt <= w_last ? '0 : r_tap_cnt + 1'b1;
        r_acc     <= r_tap_cnt == '0 ? w_ext : w_last ? r_acc : w_sum;
      end
      // a final beat always refills the output; otherwise a consumed sample empties it
      if (w_fire && w_last) begin
        out_tvalid <= 1'b1;
        out_tdata  <= w_q;
        sat_flag   <= sat_flag || w_sat;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end
endmodule
